// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory bus port.
// Optional feature macro: DMEM_TIMEOUT_EN (XFER watchdog, see dmem_port).
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } dmem_state_t;

  localparam int DMEM_AW      = 16;
  localparam int DMEM_DW      = 16;
  localparam int DMEM_TIMEOUT = 64;

endpackage

// File: rtl/dmem_watchdog.sv
// XFER watchdog: counts consecutive cycles with i_run high and flags the last
// allowed cycle, so the owner can leave XFER after exactly TIMEOUT cycles.
module dmem_watchdog
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = DMEM_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Count value TIMEOUT-1 is the TIMEOUT-th cycle of the current XFER stay.
  assign o_expired = i_run && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_port.sv
// Data-memory port: turns a held MEMREAD/MEMWRITE request into one shared-bus
// transaction (IDLE -> REQ -> XFER -> DONE). Define DMEM_TIMEOUT_EN to add the
// XFER watchdog that aborts an unacknowledged access with MEMERR.
module dmem_port
  import dmem_pkg::*;
#(
  parameter int AW      = DMEM_AW,
  parameter int DW      = DMEM_DW,
  parameter int TIMEOUT = DMEM_TIMEOUT
) (
  input  logic          clk,
  input  logic          RESETN,
  input  logic          MEMREAD,
  input  logic          MEMWRITE,
  input  logic [AW-1:0] DMADDR,
  input  logic [DW-1:0] DOUT,
  output logic [DW-1:0] DIN,
  output logic          DINVALID,
  output logic          MEMDONE,
  output logic          BUSREQ,
  input  logic          BUSGNT,
  output logic [AW-1:0] BUSADDR,
  output logic [DW-1:0] BUSWDATA,
  output logic          BUSWE,
  input  logic [DW-1:0] BUSRDATA,
  input  logic          BUSACK,
  output logic          MEMERR
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("dmem_port: TIMEOUT must be at least 2");
  end

  dmem_state_t   r_state;
  dmem_state_t   w_next;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_rd;
  logic [DW-1:0] r_din;
  logic          w_start;
  logic          w_expired;
  logic          w_err;

  assign w_start = (r_state == S_IDLE) && (MEMREAD || MEMWRITE);

`ifdef DMEM_TIMEOUT_EN
  logic r_err;

  dmem_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .i_clk    (clk),
    .i_rst_n  (RESETN),
    .i_run    (r_state == S_XFER),
    .o_expired(w_expired)
  );

  // Remembers whether the XFER -> DONE step was a watchdog abort.
  always_ff @(posedge clk or negedge RESETN) begin
    if (!RESETN) begin
      r_err <= 1'b0;
    end else if (r_state == S_XFER) begin
      r_err <= w_expired && !BUSACK;
    end
  end

  assign w_err = r_err;
`else
  assign w_expired = 1'b0;
  assign w_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (MEMREAD || MEMWRITE) w_next = S_REQ;
      S_REQ:  if (BUSGNT) w_next = S_XFER;
      S_XFER: begin
        // ACK wins over a simultaneous grant drop or watchdog expiry.
        if (BUSACK)         w_next = S_DONE;
        else if (w_expired) w_next = S_DONE;
        else if (!BUSGNT)   w_next = S_REQ;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Access is frozen at acceptance; read wins when both requests are high.
  always_ff @(posedge clk or negedge RESETN) begin
    if (!RESETN) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= 1'b0;
    end else if (w_start) begin
      r_addr  <= DMADDR;
      r_wdata <= MEMREAD ? '0 : DOUT;
      r_rd    <= MEMREAD;
    end
  end

  always_ff @(posedge clk or negedge RESETN) begin
    if (!RESETN) begin
      r_din <= '0;
    end else if ((r_state == S_XFER) && BUSACK && r_rd) begin
      r_din <= BUSRDATA;
    end
  end

  always_comb begin
    BUSREQ   = 1'b0;
    BUSADDR  = '0;
    BUSWDATA = '0;
    BUSWE    = 1'b0;
    MEMDONE  = 1'b0;
    DINVALID = 1'b0;
    MEMERR   = 1'b0;
    case (r_state)
      S_REQ:  BUSREQ = 1'b1;
      S_XFER: begin
        BUSREQ   = 1'b1;
        BUSADDR  = r_addr;
        BUSWE    = !r_rd;
        BUSWDATA = r_rd ? '0 : r_wdata;
      end
      S_DONE: begin
        MEMDONE  = 1'b1;
        DINVALID = r_rd && !w_err;
        MEMERR   = w_err;
      end
      default: ;
    endcase
  end

  assign DIN = r_din;

endmodule

// File: tb/tb_dmem_port.sv
// Scoreboard bench for dmem_port: bus responder driven from tasks, completions
// checked against a queue of expected results.
module tb_dmem_port;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          RESETN = 1'b0;
  logic          MEMREAD = 1'b0;
  logic          MEMWRITE = 1'b0;
  logic [AW-1:0] DMADDR = '0;
  logic [DW-1:0] DOUT = '0;
  logic [DW-1:0] DIN;
  logic          DINVALID;
  logic          MEMDONE;
  logic          BUSREQ;
  logic          BUSGNT = 1'b0;
  logic [AW-1:0] BUSADDR;
  logic [DW-1:0] BUSWDATA;
  logic          BUSWE;
  logic [DW-1:0] BUSRDATA = '0;
  logic          BUSACK = 1'b0;
  logic          MEMERR;

  dmem_port #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .RESETN(RESETN), .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE),
    .DMADDR(DMADDR), .DOUT(DOUT), .DIN(DIN), .DINVALID(DINVALID),
    .MEMDONE(MEMDONE), .BUSREQ(BUSREQ), .BUSGNT(BUSGNT), .BUSADDR(BUSADDR),
    .BUSWDATA(BUSWDATA), .BUSWE(BUSWE), .BUSRDATA(BUSRDATA), .BUSACK(BUSACK),
    .MEMERR(MEMERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] din;
    logic          dv;
    logic          err;
    int            done_cyc;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] model_din = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (RESETN && MEMDONE) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("din",        {16'd0, DIN}, {16'd0, e.din});
        chk("dinvalid",   {31'd0, DINVALID}, {31'd0, e.dv});
        chk("memerr",     {31'd0, MEMERR}, {31'd0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full access; gnt_low = cycles after acceptance with GNT still low,
  // drop = grant withdrawn once in XFER before ACK.
  task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                           input int gnt_low, input bit drop);
    exp_t e;
    int   e0;
    logic is_rd;
    is_rd    = rd;
    MEMREAD  = rd;
    MEMWRITE = wr;
    DMADDR   = addr;
    DOUT     = wdata;
    tick();
    e0 = cyc;
    e.din      = is_rd ? rdata : model_din;
    e.dv       = is_rd;
    e.err      = 1'b0;
    e.done_cyc = e0 + gnt_low + 2 + (drop ? 2 : 0);
    if (is_rd) model_din = rdata;
    sb.push_back(e);
    DMADDR = ~addr;
    DOUT   = ~wdata;
    for (int i = 0; i < gnt_low; i++) begin
      chk("req_busreq", {31'd0, BUSREQ}, 32'd1);
      chk("req_busaddr", {16'd0, BUSADDR}, 32'd0);
      tick();
    end
    BUSGNT = 1'b1;
    tick();
    chk("xfer_busaddr", {16'd0, BUSADDR}, {16'd0, addr});
    chk("xfer_buswe", {31'd0, BUSWE}, {31'd0, !is_rd});
    chk("xfer_buswdata", {16'd0, BUSWDATA}, is_rd ? 32'd0 : {16'd0, wdata});
    if (drop) begin
      BUSGNT = 1'b0;
      tick();
      chk("drop_busreq", {31'd0, BUSREQ}, 32'd1);
      chk("drop_busaddr", {16'd0, BUSADDR}, 32'd0);
      BUSGNT = 1'b1;
      tick();
      chk("replay_busaddr", {16'd0, BUSADDR}, {16'd0, addr});
    end
    BUSACK   = 1'b1;
    BUSRDATA = rdata;
    tick();
    BUSACK   = 1'b0;
    BUSGNT   = 1'b0;
    BUSRDATA = 16'hDEAD;
    chk("done_busreq", {31'd0, BUSREQ}, 32'd0);
    MEMREAD  = 1'b0;
    MEMWRITE = 1'b0;
    tick();
    chk("idle_memdone", {31'd0, MEMDONE}, 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_busreq", {31'd0, BUSREQ}, 32'd0);
    chk("rst_din", {16'd0, DIN}, 32'd0);
    chk("rst_memdone", {31'd0, MEMDONE}, 32'd0);
    chk("rst_memerr", {31'd0, MEMERR}, 32'd0);
    tick();
    RESETN = 1'b1;
    tick();

    do_access(1'b1, 1'b0, 16'd20,    16'h0000, 16'h0018, 1, 1'b0);
    chk("din_held", {16'd0, DIN}, 32'h0018);
    do_access(1'b0, 1'b1, 16'h00D4,  16'h00E0, 16'h5555, 1, 1'b0);
    do_access(1'b1, 1'b0, 16'h0100,  16'h0000, 16'hA5C3, 4, 1'b0);
    do_access(1'b1, 1'b1, 16'h0033,  16'hBEEF, 16'h1234, 1, 1'b0);
    do_access(1'b1, 1'b0, 16'h0077,  16'h0000, 16'hFFFF, 1, 1'b1);
    do_access(1'b0, 1'b1, 16'hFFFF,  16'hFFFF, 16'h0000, 0, 1'b1);

    // Reset while in XFER abandons the access.
    MEMREAD = 1'b1;
    DMADDR  = 16'h0042;
    tick();
    BUSGNT = 1'b1;
    tick();
    chk("pre_rst_busaddr", {16'd0, BUSADDR}, 32'h0042);
    RESETN = 1'b0;
    #1;
    chk("arst_busreq", {31'd0, BUSREQ}, 32'd0);
    chk("arst_busaddr", {16'd0, BUSADDR}, 32'd0);
    chk("arst_din", {16'd0, DIN}, 32'd0);
    chk("arst_memdone", {31'd0, MEMDONE}, 32'd0);
    model_din = '0;
    MEMREAD = 1'b0;
    BUSGNT  = 1'b0;
    tick();
    RESETN = 1'b1;
    repeat (3) tick();
    do_access(1'b1, 1'b0, 16'h0055, 16'h0000, 16'h6789, 1, 1'b0);

`ifdef DMEM_TIMEOUT_EN
    begin
      exp_t e;
      int   waited;
      MEMREAD = 1'b1;
      DMADDR  = 16'h0099;
      tick();
      BUSGNT = 1'b1;
      tick();
      e.din      = model_din;
      e.dv       = 1'b0;
      e.err      = 1'b1;
      e.done_cyc = cyc + TIMEOUT;
      sb.push_back(e);
      waited = 0;
      while (!MEMDONE && waited < 200) begin
        tick();
        waited++;
      end
      chk("timeout_wait", {31'd0, MEMDONE}, 32'd1);
      MEMREAD = 1'b0;
      BUSGNT  = 1'b0;
      tick();
      chk("timeout_idle", {31'd0, BUSREQ}, 32'd0);
    end
`endif

    repeat (3) tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
